rowbias_walker: RTL and testbench
=================================

Name: rowbias_walker

Overview:
- Requester-side controller for one tile on a row's rowbias bus.
- Drives one-hot pool indices with update strobes and reads back the broadcast busvalue.
- Rejects candidates that clash with the peer-occupied mask and holds the first legal value.
- Supports resume (try the next candidate on backtrack), exhaustion reporting, and abort. Abort parks the bus on the all-zeros pool entry.

Parameters:
w, `GRID_LEN, number of symbols; pool index is w+1 bits one-hot, where bit w selects the all-zeros value.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin a walk from pool index 0; honoured only in IDLE.
- resume  input  1  reject the held value and continue from the next index; honoured only in HOLD.
- abort  input  1  from any non-IDLE state, park the bus and return to IDLE.
- occupied  input  w  one-hot OR of values already used by row/column/block peers.
- busvalue  input  w  registered rowbias output.
- update  output  1  rowbias update strobe.
- rqindex  output  w+1  one-hot pool index to rowbias.
- value  output  w  accepted value; all zeros unless found=1.
- found  output  1  high while in HOLD.
- exhausted  output  1  one-cycle pulse when all w candidates are rejected.
- tries  output  $clog2(w+1)  candidates evaluated in the current walk.

Behaviour:
- States: IDLE, REQ, CHECK, HOLD, PARK. All outputs are registered or decoded from state.
- Reset values: state=IDLE, rqindex={1'b1,{w{1'b0}}}, update=0, value=0, found=0, exhausted=0, tries=0, internal park-reason flag=0.
- Priority: reset > abort > start/resume. start outside IDLE is ignored; resume outside HOLD is ignored; abort in IDLE is ignored.
- IDLE -> REQ on start: rqindex<=00..01, tries<=0.
- REQ (1 cycle): update=1 with rqindex stable. rowbias captures the value at the closing edge. Next state is CHECK.
- CHECK (1 cycle): update=0. busvalue is valid this cycle, and tries<=tries+1.
  - Candidate is legal iff busvalue!=0 and (busvalue & occupied)==0. occupied is sampled in this cycle only.
  - Legal: value<=busvalue, found<=1, go to HOLD.
  - Illegal and rqindex[w-1]==0: rqindex<=rqindex<<1, go to REQ.
  - Illegal and rqindex[w-1]==1: reason<=EXHAUST, go to PARK.
- HOLD: value, found and rqindex are held; update=0.
  - On resume: found<=0, value<=0. If rqindex[w-1]==1, reason<=EXHAUST and go to PARK. Otherwise rqindex<=rqindex<<1 and go to REQ.
- PARK (1 cycle): rqindex={1'b1,0...} and update=1, which drives the zeros value onto the bus. Next state is IDLE.
  - exhausted=1 in the first IDLE cycle only, iff reason==EXHAUST; reason is then cleared.
  - tries is held for inspection until the next start.
- abort in REQ, CHECK or HOLD: found<=0, value<=0, reason<=ABORT, go to PARK. No exhausted pulse is produced.
- abort takes precedence over a same-cycle resume or a same-cycle CHECK decision.
- Latency, with start sampled at edge 0:
  - First REQ in cycle 1, CHECK in cycle 2, found=1 from cycle 3.
  - Candidate k (1-based) is found in cycle 2k+1.
  - Full exhaustion puts PARK in cycle 2w+1 and the exhausted pulse in cycle 2w+2.
- rqindex is always exactly one-hot, including during reset.
- tries saturates at w and never wraps.

Test Plan:
(w=4; behavioural rowbias model with pool idx0..3 = 0010, 1000, 0001, 0100 and idx4 = 0000.)
- Reset mid-walk (during CHECK) -> next cycle: IDLE, rqindex=10000, update=0, found=0, value=0000, tries=0.
- occupied=0000, start pulse at edge 0 -> update=1/rqindex=00001 in cycle 1; found=1, value=0010, tries=1 from cycle 3.
- occupied=1010, start -> idx0 and idx1 rejected; found=1, value=0001, rqindex=00100, tries=3 in cycle 7.
- occupied=1111, start -> 4 CHECKs, then PARK in cycle 9 (update=1, rqindex=10000). exhausted pulses in cycle 10 only, bus reads 0000, tries=4.
- From HOLD at idx2 (value 0001), occupied=0000, resume -> REQ at rqindex=01000, found with value=0100. A second resume -> PARK, then an exhausted pulse.
- abort asserted together with resume in HOLD -> PARK with no exhausted pulse, then IDLE. start in HOLD and resume in IDLE produce no state change.

Source files
------------

// File: rtl/rowbias_walker.sv
// Requester-side walker for one tile on a row's rowbias bus: steps a one-hot pool
// index, checks each broadcast candidate against the peer mask and holds the first legal one.
module rowbias_walker #(
    parameter  int W  = 4,
    localparam int TW = $clog2(W + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          resume,
    input  logic          abort,
    input  logic [W-1:0]  occupied,
    input  logic [W-1:0]  busvalue,
    output logic          update,
    output logic [W:0]    rqindex,
    output logic [W-1:0]  value,
    output logic          found,
    output logic          exhausted,
    output logic [TW-1:0] tries
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CHECK,
        HOLD,
        PARK
    } state_t;

    localparam logic [W:0]    PARK_IDX  = {1'b1, {W{1'b0}}};
    localparam logic [W:0]    FIRST_IDX = {{W{1'b0}}, 1'b1};
    localparam logic [TW-1:0] TRIES_MAX = TW'(W);
    localparam logic          EXHAUST   = 1'b1;
    localparam logic          ABORTED   = 1'b0;

    state_t state_q;
    state_t state_d;
    logic   reason_q;
    logic   legal;
    logic   last_idx;

    assign legal    = (busvalue != '0) && ((busvalue & occupied) == '0);
    assign last_idx = rqindex[W-1];

    // Bus strobes both for candidate requests and for parking on the zeros entry.
    assign update = (state_q == REQ) || (state_q == PARK);
    assign found  = (state_q == HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = REQ;
            end
            REQ: begin
                state_d = abort ? PARK : CHECK;
            end
            CHECK: begin
                if (abort)         state_d = PARK;
                else if (legal)    state_d = HOLD;
                else if (last_idx) state_d = PARK;
                else               state_d = REQ;
            end
            HOLD: begin
                if (abort)       state_d = PARK;
                else if (resume) state_d = last_idx ? PARK : REQ;
            end
            PARK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rqindex   <= PARK_IDX;
            value     <= '0;
            exhausted <= 1'b0;
            tries     <= '0;
            reason_q  <= ABORTED;
        end else begin
            exhausted <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        rqindex <= FIRST_IDX;
                        tries   <= '0;
                    end
                end
                REQ: begin
                    if (abort) reason_q <= ABORTED;
                end
                CHECK: begin
                    if (abort) begin
                        value    <= '0;
                        reason_q <= ABORTED;
                    end else begin
                        if (tries != TRIES_MAX) tries <= tries + 1'b1;
                        if (legal)         value    <= busvalue;
                        else if (last_idx) reason_q <= EXHAUST;
                        else               rqindex  <= rqindex << 1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        value    <= '0;
                        reason_q <= ABORTED;
                    end else if (resume) begin
                        value <= '0;
                        if (last_idx) reason_q <= EXHAUST;
                        else          rqindex  <= rqindex << 1;
                    end
                end
                PARK: begin
                    exhausted <= reason_q;
                    reason_q  <= ABORTED;
                end
                default: ;
            endcase
            // Entering PARK always selects the all-zeros pool entry, whatever the cause.
            if (state_d == PARK) rqindex <= PARK_IDX;
        end
    end

endmodule

// File: tb/tb_rowbias_walker.sv
// Bench for rowbias_walker: table vectors, hand-written corner sequences, and randomized
// walks against a candidate-order model over a small behavioural rowbias pool.
module tb_rowbias_walker;

    localparam int W  = 4;
    localparam int TW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset, start, resume, abort;
    logic [W-1:0]  occupied, busvalue;
    logic          update, found, exhausted;
    logic [W:0]    rqindex;
    logic [W-1:0]  value;
    logic [TW-1:0] tries;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] pool [W+1];

    always #5 clock = ~clock;

    rowbias_walker #(.W(W)) dut (
        .clock(clock), .reset(reset), .start(start), .resume(resume), .abort(abort),
        .occupied(occupied), .busvalue(busvalue), .update(update), .rqindex(rqindex),
        .value(value), .found(found), .exhausted(exhausted), .tries(tries)
    );

    // Behavioural rowbias: on an update strobe, latch the pool entry the one-hot index selects.
    always_ff @(posedge clock) begin
        if (reset) begin
            busvalue <= '0;
        end else if (update) begin
            for (int i = 0; i <= W; i++)
                if (rqindex[i]) busvalue <= pool[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int next_legal(input int from, input logic [W-1:0] occ);
        for (int k = from; k < W; k++)
            if (pool[k] != '0 && (pool[k] & occ) == '0) return k;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_resume();
        resume = 1'b1;
        tick();
        resume = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Called right after the triggering edge; returns the cycle number of found or exhausted.
    task automatic wait_event(output int n, output bit got_found, output bit got_exh);
        n = 1;
        while (!found && !exhausted && n < 40) begin
            tick();
            n++;
        end
        got_found = found;
        got_exh   = exhausted;
        if (!found && !exhausted) begin
            errors++;
            $display("FAIL wait_event: no found/exhausted within %0d cycles", n);
        end
    endtask

    typedef struct {
        logic [W-1:0] occ;
        int           cyc;
        bit           fnd;
        logic [W-1:0] val;
        int           tr;
        logic [W:0]   idx;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int  n;
        bit  gf, ge;
        int  cur, j, exp_n;

        pool[0] = 4'b0010; pool[1] = 4'b1000; pool[2] = 4'b0001;
        pool[3] = 4'b0100; pool[4] = 4'b0000;

        vecs[0] = '{4'b0000,  3, 1'b1, 4'b0010, 1, 5'b00001};
        vecs[1] = '{4'b1010,  7, 1'b1, 4'b0001, 3, 5'b00100};
        vecs[2] = '{4'b1111, 10, 1'b0, 4'b0000, 4, 5'b10000};
        vecs[3] = '{4'b0010,  5, 1'b1, 4'b1000, 2, 5'b00010};
        vecs[4] = '{4'b1011,  9, 1'b1, 4'b0100, 4, 5'b01000};

        reset = 1'b1; start = 1'b0; resume = 1'b0; abort = 1'b0; occupied = '0;
        repeat (3) tick();
        check("rst_update", update, 0);
        check("rst_rqindex", rqindex, 5'b10000);
        check("rst_found", found, 0);
        check("rst_value", value, 0);
        check("rst_exh", exhausted, 0);
        check("rst_tries", tries, 0);
        reset = 1'b0;
        tick();

        // Table-driven single walks from IDLE.
        for (int v = 0; v < 5; v++) begin
            occupied = vecs[v].occ;
            pulse_start();
            check("tbl_c1_update", update, 1);
            check("tbl_c1_rqindex", rqindex, 5'b00001);
            wait_event(n, gf, ge);
            check("tbl_cycle", n, vecs[v].cyc);
            check("tbl_found", gf, vecs[v].fnd);
            check("tbl_exh", ge, !vecs[v].fnd);
            check("tbl_value", value, vecs[v].val);
            check("tbl_tries", tries, vecs[v].tr);
            check("tbl_rqindex", rqindex, vecs[v].idx);
            if (gf) begin
                pulse_abort();
                tick();
            end else begin
                tick();
            end
            check("tbl_idle_exh", exhausted, 0);
        end

        // Reset while in CHECK.
        occupied = 4'b1111;
        pulse_start();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_update", update, 0);
        check("midrst_rqindex", rqindex, 5'b10000);
        check("midrst_found", found, 0);
        check("midrst_value", value, 0);
        check("midrst_tries", tries, 0);
        tick();
        check("midrst_idle", update, 0);

        // Full exhaustion timing: PARK in cycle 9, pulse in cycle 10 only.
        occupied = 4'b1111;
        pulse_start();
        repeat (8) tick();
        check("exh_park_update", update, 1);
        check("exh_park_rqindex", rqindex, 5'b10000);
        check("exh_park_pulse", exhausted, 0);
        tick();
        check("exh_pulse", exhausted, 1);
        check("exh_bus", busvalue, 0);
        check("exh_tries", tries, 4);
        tick();
        check("exh_pulse_once", exhausted, 0);
        check("exh_tries_held", tries, 4);

        // Resume from idx2, then resume past the last index.
        occupied = 4'b1010;
        pulse_start();
        wait_event(n, gf, ge);
        check("res_first_value", value, 4'b0001);
        occupied = 4'b0000;
        pulse_resume();
        check("res_req_update", update, 1);
        check("res_req_rqindex", rqindex, 5'b01000);
        check("res_req_found", found, 0);
        tick(); tick();
        check("res_found", found, 1);
        check("res_value", value, 4'b0100);
        pulse_resume();
        check("res2_park_update", update, 1);
        check("res2_park_rqindex", rqindex, 5'b10000);
        check("res2_park_value", value, 0);
        tick();
        check("res2_exh", exhausted, 1);

        // start in HOLD ignored; abort beats resume; resume in IDLE ignored.
        pulse_start();
        wait_event(n, gf, ge);
        pulse_start();
        check("hold_start_found", found, 1);
        check("hold_start_update", update, 0);
        check("hold_start_value", value, 4'b0010);
        abort = 1'b1; resume = 1'b1;
        tick();
        abort = 1'b0; resume = 1'b0;
        check("abort_park_update", update, 1);
        check("abort_park_rqindex", rqindex, 5'b10000);
        check("abort_park_found", found, 0);
        tick();
        check("abort_no_exh", exhausted, 0);
        check("abort_idle_update", update, 0);
        pulse_resume();
        check("idle_resume_update", update, 0);
        check("idle_resume_found", found, 0);
        tick();
        check("idle_resume_update2", update, 0);

        // Randomized walks against the candidate-order model.
        for (int t = 0; t < 40; t++) begin
            occupied = 4'($urandom_range(0, 15));
            pulse_start();
            cur = -1;
            forever begin
                j = next_legal(cur + 1, occupied);
                exp_n = (j >= 0) ? 2 * (j - cur) + 1 : 2 * (W - 1 - cur) + 2;
                wait_event(n, gf, ge);
                check("rnd_cycle", n, exp_n);
                check("rnd_found", gf, j >= 0);
                if (j < 0) begin
                    check("rnd_exh_tries", tries, W);
                    tick();
                    break;
                end
                check("rnd_value", value, pool[j]);
                check("rnd_tries", tries, j + 1);
                check("rnd_rqindex", rqindex, 1 << j);
                cur = j;
                if ($urandom_range(0, 3) == 0) begin
                    pulse_abort();
                    tick();
                    check("rnd_abort_exh", exhausted, 0);
                    break;
                end
                if ($urandom_range(0, 1) == 0) occupied = 4'($urandom_range(0, 15));
                pulse_resume();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
